// File: rtl/ndp_pkg.sv
// Shared constants and state encoding for the NDP ingress sequencer.
// Beat-count helpers let each instance derive counts from its own parameters.
package ndp_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_ACT   = 3'd1;
    localparam state_t S_WGT   = 3'd2;
    localparam state_t S_STEP  = 3'd3;
    localparam state_t S_WAIT  = 3'd4;
    localparam state_t S_DRAIN = 3'd5;

    localparam int WIDTH_DEF  = 16;
    localparam int AXIS_W_DEF = 32;
    localparam int A_ROWS_DEF = 4;
    localparam int B_COLS_DEF = 64;

    function automatic int na_of(input int a_rows);
        return a_rows / 2;
    endfunction

    function automatic int nb_of(input int b_cols);
        return b_cols / 2;
    endfunction

    function automatic int nr_of(input int a_rows, input int b_cols,
                                 input int width, input int axis_w);
        return (a_rows * b_cols * width) / axis_w;
    endfunction

    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int NA = na_of(A_ROWS_DEF);
    localparam int NB = nb_of(B_COLS_DEF);
    localparam int NR = nr_of(A_ROWS_DEF, B_COLS_DEF, WIDTH_DEF, AXIS_W_DEF);

    localparam bit AXIS_W_OK = (AXIS_W_DEF == 2 * WIDTH_DEF);

endpackage

// File: rtl/ndp_result_serializer.sv
// Drains the flattened result matrix as a stream of AXIS_W-bit beats.
// One start pulse sends N_RES beats; done pulses as the last one is taken.
module ndp_result_serializer
    import ndp_pkg::*;
#(
    parameter int AXIS_W = 32,
    parameter int N_RES  = 128
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [N_RES*AXIS_W-1:0]   result,
    input  logic                      m_axis_tready,
    output logic [AXIS_W-1:0]         m_axis_tdata,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    output logic                      done
);

    localparam int LW = cnt_w(N_RES);
    localparam logic [LW-1:0] L_LAST = LW'(N_RES - 1);

    logic          active;
    logic [LW-1:0] l;
    logic          at_last;

    assign at_last       = (l == L_LAST);
    assign m_axis_tvalid = active;
    assign m_axis_tlast  = active && at_last;
    assign done          = active && m_axis_tready && at_last;

    // Beat mux is gated so the port reads zero outside a drain.
    always_comb begin
        m_axis_tdata = '0;
        if (active)
            m_axis_tdata = result[l*AXIS_W +: AXIS_W];
    end

    // Beat index advances only on an accepted beat, so data holds on stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= 1'b0;
            l      <= '0;
        end else if (start) begin
            active <= 1'b1;
            l      <= '0;
        end else if (active && m_axis_tready) begin
            if (at_last) begin
                active <= 1'b0;
                l      <= '0;
            end else begin
                l <= l + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ndp_ingress_sequencer.sv
// Host stream to systolic-array sequencer: loads one activation column and
// one weight row per step, runs K_DEPTH steps, then streams the result out.
module ndp_ingress_sequencer
    import ndp_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int AXIS_W  = 32,
    parameter int A_ROWS  = 4,
    parameter int B_COLS  = 64,
    parameter int K_DEPTH = 21
) (
    input  logic                             axi_aclk,
    input  logic                             reset,
    input  logic [AXIS_W-1:0]                s_axis_tdata,
    input  logic                             s_axis_tvalid,
    input  logic                             s_axis_tlast,
    output logic                             s_axis_tready,
    output logic                             arr_clear,
    output logic                             arr_step,
    input  logic                             arr_ready,
    output logic [A_ROWS*WIDTH-1:0]          arr_act,
    output logic [B_COLS*WIDTH-1:0]          arr_wgt,
    input  logic                             arr_done,
    input  logic [A_ROWS*B_COLS*WIDTH-1:0]   arr_result,
    output logic [AXIS_W-1:0]                m_axis_tdata,
    output logic                             m_axis_tvalid,
    output logic                             m_axis_tlast,
    input  logic                             m_axis_tready,
    output logic                             busy,
    output logic                             err_framing
);

    localparam int N_ACT = na_of(A_ROWS);
    localparam int N_WGT = nb_of(B_COLS);
    localparam int N_RES = nr_of(A_ROWS, B_COLS, WIDTH, AXIS_W);
    localparam int IW    = cnt_w((N_ACT > N_WGT) ? N_ACT : N_WGT);
    localparam int KW    = cnt_w(K_DEPTH + 1);

    localparam logic [IW-1:0] ACT_LAST = IW'(N_ACT - 1);
    localparam logic [IW-1:0] WGT_LAST = IW'(N_WGT - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(K_DEPTH - 1);

    if (AXIS_W != 2 * WIDTH || (A_ROWS % 2) != 0 ||
        (B_COLS % 2) != 0 || K_DEPTH < 1) begin : g_cfg_bad
        $error("ndp_ingress_sequencer: bad parameter set");
    end

    state_t        state;
    logic [IW-1:0] i;
    logic [KW-1:0] k;
    logic          beat_ok;
    logic          act_end;
    logic          wgt_end;
    logic          job_end;
    logic          ser_start;
    logic          ser_done;

    assign s_axis_tready = (state == S_ACT) || (state == S_WGT);
    assign arr_step      = (state == S_STEP);
    assign beat_ok       = s_axis_tvalid && s_axis_tready;
    assign act_end       = (i == ACT_LAST);
    assign wgt_end       = (i == WGT_LAST);
    assign job_end       = wgt_end && (k == K_LAST);
    assign ser_start     = (state == S_WAIT) && arr_done;

    // Job FSM: parse column/row beats, hand steps to the array, then drain.
    always_ff @(posedge axi_aclk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            i           <= '0;
            k           <= '0;
            arr_clear   <= 1'b0;
            busy        <= 1'b0;
            err_framing <= 1'b0;
            arr_act     <= '0;
            arr_wgt     <= '0;
        end else begin
            arr_clear <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (s_axis_tvalid) begin
                        arr_clear   <= 1'b1;
                        err_framing <= 1'b0;
                        busy        <= 1'b1;
                        k           <= '0;
                        i           <= '0;
                        state       <= S_ACT;
                    end
                end
                S_ACT: begin
                    if (beat_ok) begin
                        arr_act[i*AXIS_W +: AXIS_W] <= s_axis_tdata;
                        if (s_axis_tlast) begin
                            err_framing <= 1'b1;
                            busy        <= 1'b0;
                            i           <= '0;
                            state       <= S_IDLE;
                        end else if (act_end) begin
                            i     <= '0;
                            state <= S_WGT;
                        end else begin
                            i <= i + 1'b1;
                        end
                    end
                end
                S_WGT: begin
                    if (beat_ok) begin
                        arr_wgt[i*AXIS_W +: AXIS_W] <= s_axis_tdata;
                        if (s_axis_tlast && !job_end) begin
                            err_framing <= 1'b1;
                            busy        <= 1'b0;
                            i           <= '0;
                            state       <= S_IDLE;
                        end else if (wgt_end) begin
                            if (job_end && !s_axis_tlast)
                                err_framing <= 1'b1;
                            i     <= '0;
                            state <= S_STEP;
                        end else begin
                            i <= i + 1'b1;
                        end
                    end
                end
                S_STEP: begin
                    if (arr_ready) begin
                        k     <= k + 1'b1;
                        state <= (k == K_LAST) ? S_WAIT : S_ACT;
                    end
                end
                S_WAIT: begin
                    if (arr_done)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (ser_done) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    ndp_result_serializer #(
        .AXIS_W (AXIS_W),
        .N_RES  (N_RES)
    ) u_ser (
        .clk           (axi_aclk),
        .rst           (reset),
        .start         (ser_start),
        .result        (arr_result),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .done          (ser_done)
    );

endmodule
